// File: rtl/dct_pkg.sv
// Shared widths, pipeline tag type and the round/saturate helper for the fdct
// multiply-accumulate path and the quantizer.
package dct_pkg;

    localparam int DEF_DATA_W  = 8;
    localparam int DEF_COEF_W  = 16;
    localparam int DEF_TAPS    = 8;
    localparam int DEF_FRAC_SH = 12;
    localparam int DEF_RES_W   = 22;

    // Working width of round_sat; callers sign-extend into it and truncate out.
    localparam int RS_W = 64;

    typedef struct packed {
        logic v;
        logic first;
        logic last;
    } dct_tag_t;

    function automatic logic signed [RS_W-1:0] round_sat(
        input logic signed [RS_W-1:0] acc,
        input int                     frac_sh,
        input int                     res_w
    );
        logic signed [RS_W-1:0] one;
        logic signed [RS_W-1:0] tmp;
        logic signed [RS_W-1:0] max_v;
        logic signed [RS_W-1:0] min_v;
        one = 1;
        if (frac_sh > 0) begin
            tmp = (acc + (one <<< (frac_sh - 1))) >>> frac_sh;
        end else begin
            tmp = acc;
        end
        max_v = (one <<< (res_w - 1)) - one;
        min_v = -(one <<< (res_w - 1));
        if (tmp > max_v) begin
            return max_v;
        end else if (tmp < min_v) begin
            return min_v;
        end
        return tmp;
    endfunction

endpackage

// File: rtl/dct_round_sat.sv
// Combinational round-half-up and saturate from accumulator width down to the
// result width; shared with the quantizer.
module dct_round_sat
    import dct_pkg::*;
#(
    parameter int ACC_W   = 27,
    parameter int FRAC_SH = DEF_FRAC_SH,
    parameter int RES_W   = DEF_RES_W
) (
    input  logic signed [ACC_W-1:0] acc,
    output logic signed [RES_W-1:0] res
);

    logic signed [RS_W-1:0] acc_ext;

    assign acc_ext = {{(RS_W - ACC_W){acc[ACC_W-1]}}, acc};
    assign res     = RES_W'(round_sat(acc_ext, FRAC_SH, RES_W));

endmodule

// File: rtl/dct_mac_unit.sv
// Multiply-accumulate engine of one fdct DCT unit: TAPS products per group,
// rounded and saturated into a registered result with a one-cycle out_valid.
module dct_mac_unit
    import dct_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int COEF_W  = DEF_COEF_W,
    parameter int TAPS    = DEF_TAPS,
    parameter int FRAC_SH = DEF_FRAC_SH,
    parameter int RES_W   = DEF_RES_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic                     in_first,
    input  logic signed [DATA_W-1:0] din,
    input  logic signed [COEF_W-1:0] coef,
    output logic signed [RES_W-1:0]  result,
    output logic                     out_valid,
    output logic                     busy
);

    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = DATA_W + COEF_W + $clog2(TAPS);
    localparam int CNT_W  = $clog2(TAPS);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(TAPS - 1);

    logic [CNT_W-1:0]         cnt;
    logic [CNT_W-1:0]         idx;
    logic                     is_last;
    logic signed [PROD_W-1:0] prod_p0;
    dct_tag_t                 tag_p0;
    logic signed [ACC_W-1:0]  acc_p1;
    dct_tag_t                 tag_p1;
    logic signed [RES_W-1:0]  rs_res;

    // in_first restarts the group at index 0, dropping any partial group.
    assign idx     = in_first ? '0 : cnt;
    assign is_last = (idx == LAST_IDX);
    assign busy    = (cnt != '0) | tag_p0.v | tag_p1.v;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (in_valid) begin
            cnt <= is_last ? '0 : idx + CNT_W'(1);
        end
    end

    // S1: product and tag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_p0 <= '0;
            tag_p0  <= '0;
        end else begin
            tag_p0.v     <= in_valid;
            tag_p0.first <= in_valid && (idx == '0);
            tag_p0.last  <= in_valid && is_last;
            if (in_valid) begin
                prod_p0 <= PROD_W'(din) * PROD_W'(coef);
            end
        end
    end

    // S2: accumulate, reloading on the first sample of a group
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_p1 <= '0;
            tag_p1 <= '0;
        end else begin
            tag_p1 <= tag_p0;
            if (tag_p0.v) begin
                acc_p1 <= tag_p0.first ? ACC_W'(prod_p0) : acc_p1 + ACC_W'(prod_p0);
            end
        end
    end

    dct_round_sat #(
        .ACC_W  (ACC_W),
        .FRAC_SH(FRAC_SH),
        .RES_W  (RES_W)
    ) u_round_sat (
        .acc(acc_p1),
        .res(rs_res)
    );

    // S3: registered result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result    <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= tag_p1.v && tag_p1.last;
            if (tag_p1.v && tag_p1.last) begin
                result <= rs_res;
            end
        end
    end

endmodule

// File: tb/tb_dct_mac_unit.sv
// Scoreboard bench for dct_mac_unit: a default-width instance and a RES_W=12
// instance share the stimulus; each has its own expected-result queue.
module tb_dct_mac_unit;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic               in_first;
    logic signed [7:0]  din;
    logic signed [15:0] coef;
    logic signed [21:0] res_a;
    logic signed [11:0] res_b;
    logic               ov_a, ov_b, busy_a, busy_b;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        longint res;
        int     cyc;
        bit     busy;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    dct_mac_unit dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_first(in_first),
        .din(din), .coef(coef), .result(res_a), .out_valid(ov_a), .busy(busy_a)
    );

    dct_mac_unit #(.RES_W(12)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_first(in_first),
        .din(din), .coef(coef), .result(res_b), .out_valid(ov_b), .busy(busy_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic smp(input bit v, input bit f, input int d, input int c);
        @(posedge clk);
        #1;
        in_valid = v;
        in_first = f;
        din      = 8'(d);
        coef     = 16'(c);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) smp(1'b0, 1'b0, 0, 0);
    endtask

    // Call right after driving the last sample of a group.
    task automatic push(input longint ea, input longint eb, input bit bz);
        exp_t e;
        e.res  = ea;
        e.cyc  = cyc + 3;
        e.busy = bz;
        q_a.push_back(e);
        e.res = eb;
        q_b.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1) begin
            if (ov_a) begin
                if (q_a.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_pulse_a: result %0d with no pending group (cycle %0d)", res_a, cyc);
                end else begin
                    e = q_a.pop_front();
                    chk("result_a", res_a, e.res);
                    chk("latency_a", cyc, e.cyc);
                    chk("busy_at_pulse_a", busy_a, e.busy);
                end
            end
            if (ov_b) begin
                if (q_b.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_pulse_b: result %0d with no pending group (cycle %0d)", res_b, cyc);
                end else begin
                    e = q_b.pop_front();
                    chk("result_b", res_b, e.res);
                    chk("latency_b", cyc, e.cyc);
                    chk("busy_at_pulse_b", busy_b, e.busy);
                end
            end
        end
    end

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_first = 1'b0;
        din      = '0;
        coef     = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_result_a", res_a, 0);
        chk("reset_valid_a", ov_a, 0);
        chk("reset_busy_a", busy_a, 0);
        chk("reset_result_b", res_b, 0);
        chk("reset_valid_b", ov_b, 0);
        chk("reset_busy_b", busy_b, 0);
        rst_n = 1'b1;

        // 10 * 4096 * 8 >> 12 = 80
        for (int i = 0; i < 8; i++) smp(1'b1, i == 0, 10, 4096);
        push(80, 80, 1'b0);
        idle(5);

        // acc = +/-2048: half rounds up to 1, and -0.5 rounds up to 0
        smp(1'b1, 1'b1, 1, 2048);
        for (int i = 1; i < 8; i++) smp(1'b1, 1'b0, 1, 0);
        push(1, 1, 1'b0);
        idle(5);
        smp(1'b1, 1'b1, -1, 2048);
        for (int i = 1; i < 8; i++) smp(1'b1, 1'b0, -1, 0);
        push(0, 0, 1'b0);
        idle(5);

        // 8128 and -8192: in range for 22 bits, clamped for 12 bits
        for (int i = 0; i < 8; i++) smp(1'b1, i == 0, 127, 32767);
        push(8128, 2047, 1'b0);
        idle(5);
        for (int i = 0; i < 8; i++) smp(1'b1, i == 0, -128, 32767);
        push(-8192, -2048, 1'b0);
        idle(5);

        // din 1..8, coef 4096 -> 36, unstalled then with a 3-cycle gap
        for (int i = 0; i < 8; i++) smp(1'b1, i == 0, i + 1, 4096);
        push(36, 36, 1'b0);
        idle(5);
        for (int i = 0; i < 8; i++) begin
            smp(1'b1, i == 0, i + 1, 4096);
            if (i == 4) idle(3);
        end
        push(36, 36, 1'b0);
        idle(5);

        // 5 samples abandoned by in_first, then a full group of 2*4096 -> 16
        for (int i = 0; i < 5; i++) smp(1'b1, i == 0, 5, 4096);
        for (int i = 0; i < 8; i++) smp(1'b1, i == 0, 2, 4096);
        push(16, 16, 1'b0);
        idle(5);

        // back-to-back groups: 8 then 24, 8 cycles apart, third group cut by reset
        for (int i = 0; i < 16; i++) begin
            smp(1'b1, i == 0, (i < 8) ? 1 : 3, 4096);
            if (i == 7) push(8, 8, 1'b1);
            if (i == 15) push(24, 24, 1'b1);
        end
        for (int i = 0; i < 4; i++) smp(1'b1, 1'b0, 7, 4096);
        @(posedge clk);
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("async_reset_result_a", res_a, 0);
        chk("async_reset_valid_a", ov_a, 0);
        chk("async_reset_busy_a", busy_a, 0);
        chk("async_reset_result_b", res_b, 0);
        chk("async_reset_valid_b", ov_b, 0);
        chk("async_reset_busy_b", busy_b, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // first group after reset, no in_first -> 8
        for (int i = 0; i < 8; i++) smp(1'b1, 1'b0, 1, 4096);
        push(8, 8, 1'b0);
        idle(6);

        chk("pending_groups_a", q_a.size(), 0);
        chk("pending_groups_b", q_b.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dct_mac_unit.md
Name: dct_mac_unit

Overview:
- Multiply-accumulate engine inside each DCT unit of the fdct stage of jpeg_encoder.
- Each cycle with a valid sample, it takes one pixel and one cosine coefficient and accumulates their product. After 8 products it rounds and saturates the sum and presents it on a registered result.
- The result register is the one consumed by the downstream dct_unit/zigzag path.

Parameters:
- DATA_W, 8, signed sample width (level-shifted pixel)
- COEF_W, 16, signed cosine coefficient width
- TAPS, 8, products per result (power of two)
- FRAC_SH, 12, right shift applied to the accumulator before output
- RES_W, 22, signed result width
- ACC_W, DATA_W+COEF_W+$clog2(TAPS), accumulator width (derived, not overridden)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  din/coef valid this cycle
- in_first  in  1  qualifies the first sample of a TAPS-sample group
- din  in  DATA_W  signed sample
- coef  in  COEF_W  signed coefficient
- result  out  RES_W  signed, rounded, saturated sum
- out_valid  out  1  one-cycle pulse: result updated this cycle
- busy  out  1  group in progress (count != 0 or pipeline non-empty)

Behaviour:
- Interface fixed: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset values:
  - result=0, out_valid=0, busy=0.
  - Sample counter, product register, accumulator and pipeline valids all cleared.
- Pipeline (all registered):
  - S1: prod = din*coef (full DATA_W+COEF_W signed) and tag {v, first, last}.
  - S2: acc = first ? sext(prod) : acc + sext(prod).
  - S3: on last, result = sat(round(acc)) and out_valid pulses.
- Latency: the TAPS-th sample accepted at cycle T gives out_valid=1 and the new result at T+3. out_valid=1 for exactly one cycle. result holds between pulses.
- Counter cnt (0..TAPS-1):
  - Accepted sample = in_valid high.
  - cnt increments on each accepted sample. The sample at cnt==TAPS-1 is tagged last, and cnt wraps to 0.
  - in_first with in_valid forces that sample to index 0, so cnt becomes 1. An incomplete group in progress is abandoned with no out_valid.
  - in_first without in_valid is ignored.
- Stall: in_valid low holds cnt and acc. No bubble affects the sum. Gaps of any length are allowed inside a group.
- Back-to-back groups:
  - A sample tagged first reaching S2 on the cycle after a last sample loads acc directly. No dead cycle.
  - Continuous input gives one out_valid every TAPS cycles.
- Rounding: round-half-up. tmp = (acc + 2^(FRAC_SH-1)) >>> FRAC_SH, arithmetic shift, computed at ACC_W+1 bits so the add cannot overflow.
- Saturation: tmp above 2^(RES_W-1)-1 clamps to the max; tmp below -2^(RES_W-1) clamps to the min.
- No backpressure. The consumer must take result on out_valid.
- Reset mid-group: everything clears asynchronously. The first group after reset starts at cnt=0 even without in_first.
- busy = (cnt != 0) | S1.v | S2.v.

Decomposition:
- Package dct_pkg holds:
  - default widths (DATA_W, COEF_W, TAPS, FRAC_SH, RES_W)
  - function round_sat(acc, FRAC_SH, RES_W)
  - typedef dct_tag_t {v, first, last} for the pipeline tag
- One sub-module, dct_round_sat: combinational round+saturate, instantiated once feeding the S3 register. This keeps it reusable by the quantizer.

Test Plan:
- 8 samples din=10, coef=4096, in_first on sample 0 -> out_valid 3 cycles after the 8th sample, result=80. busy falls on that cycle.
- din=1, coef=2048 on sample 0, coef=0 on samples 1-7 -> acc=2048, result=1 (half rounds up). Repeat with din=-1 -> acc=-2048, result=0.
- RES_W=12, din=127, coef=32767 for all 8 -> raw 8128 saturates to 2047. din=-128, coef=32767 for all 8 -> -8191.75 -> -8192 saturates to -2048.
- Group of 8 with in_valid deasserted for 3 cycles after sample 4 -> same result as the unstalled run. out_valid is delayed by 3 cycles.
- 5 samples, then in_first plus 8 samples din=2, coef=4096 -> exactly one out_valid, result=16. The abandoned group gives no pulse.
- 16 continuous samples (two groups, din=1 then din=3, coef=4096) -> out_valid pulses 8 cycles apart with results 8 then 24. Asserting rst_n=0 mid third group -> result=0, out_valid=0, busy=0 immediately, without waiting for a clock edge.
